// File: rtl/seg_menu_pkg.sv
// Shared types and segment encodings for the 7-segment menu controller.
// Segment bytes are {a,b,c,d,e,f,g,dp}, active-high.
package seg_menu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL_A, ST_SEL_B, ST_RUN_P, ST_RUN_C, ST_RUN_E, ST_FINISH
  } state_t;

  typedef enum logic [1:0] {GRP_NONE, GRP_A, GRP_B} group_t;

  localparam logic [2:0] CMD_A      = 3'd1;
  localparam logic [2:0] CMD_B      = 3'd2;
  localparam logic [2:0] CMD_P      = 3'd3;
  localparam logic [2:0] CMD_C      = 3'd4;
  localparam logic [2:0] CMD_E      = 3'd5;
  localparam logic [2:0] CMD_CANCEL = 3'd7;

  localparam logic [7:0] SEG_H     = 8'b01101110;
  localparam logic [7:0] SEG_A     = 8'b11101110;
  localparam logic [7:0] SEG_B     = 8'b11111110;
  localparam logic [7:0] SEG_P     = 8'b11001110;
  localparam logic [7:0] SEG_C     = 8'b10011100;
  localparam logic [7:0] SEG_E     = 8'b10011110;
  localparam logic [7:0] SEG_G     = 8'b10111110;
  localparam logic [7:0] SEG_BLANK = 8'b00000000;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: seg_digit = 8'b11111100;
      4'd1: seg_digit = 8'b01100000;
      4'd2: seg_digit = 8'b11011010;
      4'd3: seg_digit = 8'b11110010;
      4'd4: seg_digit = 8'b01100110;
      4'd5: seg_digit = 8'b10110110;
      4'd6: seg_digit = 8'b10111110;
      4'd7: seg_digit = 8'b11100000;
      4'd8: seg_digit = 8'b11111110;
      4'd9: seg_digit = 8'b11110110;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  function automatic logic is_timed(input state_t s);
    is_timed = (s == ST_RUN_P) || (s == ST_RUN_C) || (s == ST_RUN_E) || (s == ST_FINISH);
  endfunction

  function automatic logic [7:0] state_letter(input state_t s);
    case (s)
      ST_IDLE:   state_letter = SEG_H;
      ST_SEL_A:  state_letter = SEG_A;
      ST_SEL_B:  state_letter = SEG_B;
      ST_RUN_P:  state_letter = SEG_P;
      ST_RUN_C:  state_letter = SEG_C;
      ST_RUN_E:  state_letter = SEG_E;
      ST_FINISH: state_letter = SEG_G;
      default:   state_letter = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_menu_ctrl_if.sv
// Command/display bundle between the operator side (master) and the controller (slave).
interface seg_menu_ctrl_if #(parameter int DIGITS = 4);
  logic [2:0]        cmd;
  logic              cmd_valid;
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;
  logic              busy;
  logic              phase_done;

  modport master (output cmd, cmd_valid, input seg, an, busy, phase_done);
  modport slave  (input cmd, cmd_valid, output seg, an, busy, phase_done);
endinterface

// File: rtl/seg_menu_ctrl_scan.sv
// Digit multiplexer: walks the digits every SCAN_DIV cycles and registers seg/an together.
// SEG_ACTIVE_LOW_EN inverts both outputs (and their reset value) for common-anode boards.
module seg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGITS-1:0][7:0] codes_i,
  output logic [7:0]             seg_o,
  output logic [DIGITS-1:0]      an_o
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
`ifdef SEG_ACTIVE_LOW_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    an_d        = '0;
    an_d[idx_q] = 1'b1;
    seg_d       = codes_i[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= {8{POL}};
      an_q  <= {DIGITS{POL}};
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d ^ {8{POL}};
      an_q  <= an_d ^ {DIGITS{POL}};
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;
endmodule

// File: rtl/seg_menu_ctrl.sv
// Two-level menu FSM with self-timed run/finish phases driving a multiplexed 7-seg display.
// Optional build macro: SEG_ACTIVE_LOW_EN (inverted seg/an, handled in seg_scan).
module seg_menu_ctrl
  import seg_menu_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int TICK_DIV    = 50_000_000,
  parameter int PHASE_TICKS = 3
) (
  input logic            clk,
  input logic            rst,
  seg_menu_ctrl_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t  state_q, state_d;
  group_t  grp_q, grp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    rem_q, rem_d;
  logic          busy_q, done_q, done_d;
  logic          tick, expire, cancel;
  logic [DIGITS-1:0][7:0] codes;

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    tick    = (presc_q == PW'(TICK_DIV - 1));
    expire  = tick && (rem_q == 4'd1);
    cancel  = bus.cmd_valid && (bus.cmd == CMD_CANCEL) && (state_q != ST_IDLE);

    if (is_timed(state_q)) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) rem_d = rem_q - 1'b1;
    end

    // CANCEL outranks a same-cycle expiry and suppresses phase_done
    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.cmd_valid) begin
          if (bus.cmd == CMD_A)      state_d = ST_SEL_A;
          else if (bus.cmd == CMD_B) state_d = ST_SEL_B;
        end
        ST_SEL_A, ST_SEL_B: if (bus.cmd_valid) begin
          if (bus.cmd == CMD_P)      state_d = ST_RUN_P;
          else if (bus.cmd == CMD_C) state_d = ST_RUN_C;
          else if (bus.cmd == CMD_E) state_d = ST_RUN_E;
        end
        ST_RUN_P: if (expire) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end
        ST_RUN_C, ST_RUN_E, ST_FINISH: if (expire) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Entry actions: timed states restart the prescaler and reload the countdown
    if (state_d != state_q) begin
      presc_d = '0;
      rem_d   = is_timed(state_d) ? 4'(PHASE_TICKS) : 4'd0;
      case (state_d)
        ST_SEL_A: grp_d = GRP_A;
        ST_SEL_B: grp_d = GRP_B;
        ST_IDLE:  grp_d = GRP_NONE;
        default:  grp_d = grp_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grp_q   <= GRP_NONE;
      presc_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      busy_q  <= is_timed(state_d);
      done_q  <= done_d;
    end
  end

  always_comb begin
    codes    = '0;
    codes[0] = state_letter(state_q);
    if (is_timed(state_q)) codes[1] = seg_digit(rem_q);
    case (grp_q)
      GRP_A:   codes[DIGITS-1] = SEG_A;
      GRP_B:   codes[DIGITS-1] = SEG_B;
      default: codes[DIGITS-1] = SEG_BLANK;
    endcase
  end

  seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .codes_i (codes),
    .seg_o   (bus.seg),
    .an_o    (bus.an)
  );

  assign bus.busy       = busy_q;
  assign bus.phase_done = done_q;
endmodule

// File: tb/tb_seg_menu_ctrl.sv
// Bench for seg_menu_ctrl: cycle-accurate scoreboard from a time-based behavioural model,
// a vector table of command steps, and hand sequences for expiry, cancel and reset.
module tb_seg_menu_ctrl;
  localparam int DIGITS = 4, SCAN_DIV = 2, TICK_DIV = 4, PHASE_TICKS = 3;
  localparam int PH = PHASE_TICKS * TICK_DIV;
`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [7:0]        SINV = 8'hFF;
  localparam logic [DIGITS-1:0] AINV = '1;
`else
  localparam logic [7:0]        SINV = 8'h00;
  localparam logic [DIGITS-1:0] AINV = '0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_menu_ctrl_if #(.DIGITS(DIGITS)) bus();
  seg_menu_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .TICK_DIV(TICK_DIV),
                  .PHASE_TICKS(PHASE_TICKS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic              busy;
    logic              pd;
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;
  } exp_t;

  typedef struct {
    logic [2:0] cmd;
    logic       vld;
    int         wait_cyc;
    byte        letter;
    logic       busy;
  } vec_t;

  exp_t sbq[$];
  int   errors = 0, checks = 0, pd_cnt = 0;
  bit   mon_en = 0;
  logic [7:0] last_seg [DIGITS];

  // behavioural model: state letter, group letter, cycles left in the phase
  byte m_st = "H", m_grp = 0;
  int  m_cl = 0, n_edge = 0;
  bit  m_pd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lseg(input byte ch);
    case (ch)
      "H": return 8'b01101110;
      "A": return 8'b11101110;
      "B": return 8'b11111110;
      "P": return 8'b11001110;
      "C": return 8'b10011100;
      "E": return 8'b10011110;
      "G": return 8'b10111110;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] dseg(input int d);
    logic [7:0] tbl [10] = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110,
                             8'b10110110, 8'b10111110, 8'b11100000, 8'b11111110, 8'b11110110};
    return tbl[d];
  endfunction

  function automatic bit timed(input byte s);
    return (s == "P") || (s == "C") || (s == "E") || (s == "G");
  endfunction

  function automatic logic [7:0] disp(input int dig);
    if (dig == 0) return lseg(m_st);
    if (dig == 1) return timed(m_st) ? dseg((m_cl + TICK_DIV - 1) / TICK_DIV) : 8'h00;
    if (dig == DIGITS - 1) return (m_grp == 0) ? 8'h00 : lseg(m_grp);
    return 8'h00;
  endfunction

  task automatic model_step(input logic [2:0] c, input logic v);
    m_pd = 0;
    if (v && c == 3'd7 && m_st != "H") begin
      m_st = "H"; m_grp = 0;
    end else if (timed(m_st)) begin
      m_cl--;
      if (m_cl == 0) begin
        m_pd = 1;
        if (m_st == "P") begin m_st = "G"; m_cl = PH; end
        else begin m_st = "H"; m_grp = 0; end
      end
    end else if (v) begin
      if (m_st == "H") begin
        if (c == 3'd1) begin m_st = "A"; m_grp = "A"; end
        else if (c == 3'd2) begin m_st = "B"; m_grp = "B"; end
      end else begin
        if (c == 3'd3) begin m_st = "P"; m_cl = PH; end
        else if (c == 3'd4) begin m_st = "C"; m_cl = PH; end
        else if (c == 3'd5) begin m_st = "E"; m_cl = PH; end
      end
    end
  endtask

  // Drive one cycle of stimulus; push what the DUT must show after this edge.
  task automatic tick(input logic [2:0] c, input logic v);
    exp_t e;
    int dig;
    bus.cmd = c; bus.cmd_valid = v;
    @(posedge clk);
    n_edge++;
    dig = ((n_edge - 1) / SCAN_DIV) % DIGITS;
    e.seg = disp(dig);
    e.an = '0; e.an[dig] = 1'b1;
    model_step(c, v);
    e.busy = timed(m_st);
    e.pd = m_pd;
    sbq.push_back(e);
    #1;
    bus.cmd = 3'd0; bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk({tag, "_seg_now"}, bus.seg, SINV);
    chk({tag, "_an_now"}, bus.an, AINV);
    chk({tag, "_busy_now"}, bus.busy, 1'b0);
    chk({tag, "_pd_now"}, bus.phase_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_seg_hold"}, bus.seg, SINV);
    chk({tag, "_an_hold"}, bus.an, AINV);
    sbq.delete();
    m_st = "H"; m_grp = 0; m_cl = 0; m_pd = 0; n_edge = 0;
    for (int i = 0; i < DIGITS; i++) last_seg[i] = 8'hXX;
    rst = 1'b0;
    mon_en = 1;
  endtask

  initial begin : monitor
    logic [7:0] sn;
    logic [DIGITS-1:0] an_n;
    exp_t e;
    forever begin
      @(negedge clk);
      sn = bus.seg ^ SINV;
      an_n = bus.an ^ AINV;
      if (mon_en && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("busy", bus.busy, e.busy);
        chk("phase_done", bus.phase_done, e.pd);
        chk("an", an_n, e.an);
        chk("seg", sn, e.seg);
      end
      if (!rst) begin
        for (int i = 0; i < DIGITS; i++) if (an_n == (DIGITS'(1) << i)) last_seg[i] = sn;
        if (bus.phase_done) pd_cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t vec [13];
    int pd0;
    vec[0]  = '{3'd0, 1'b0,  9, "H", 1'b0};
    vec[1]  = '{3'd6, 1'b1,  9, "H", 1'b0};
    vec[2]  = '{3'd0, 1'b1,  9, "H", 1'b0};
    vec[3]  = '{3'd1, 1'b0,  9, "H", 1'b0};
    vec[4]  = '{3'd1, 1'b1,  9, "A", 1'b0};
    vec[5]  = '{3'd4, 1'b1, 22, "H", 1'b0};
    vec[6]  = '{3'd2, 1'b1,  9, "B", 1'b0};
    vec[7]  = '{3'd0, 1'b1,  9, "B", 1'b0};
    vec[8]  = '{3'd6, 1'b1,  9, "B", 1'b0};
    vec[9]  = '{3'd3, 1'b0,  9, "B", 1'b0};
    vec[10] = '{3'd1, 1'b1,  9, "B", 1'b0};
    vec[11] = '{3'd3, 1'b1, 10, "P", 1'b1};
    vec[12] = '{3'd0, 1'b0, 22, "H", 1'b0};

    bus.cmd = 3'd0; bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    do_reset("por");

    for (int i = 0; i < 13; i++) begin
      tick(vec[i].cmd, vec[i].vld);
      repeat (vec[i].wait_cyc) tick(3'd0, 1'b0);
      chk($sformatf("vec%0d_busy", i), bus.busy, vec[i].busy);
      chk($sformatf("vec%0d_letter", i), last_seg[0], lseg(vec[i].letter));
    end

    // RUN_C lasts exactly PH cycles and ends with a single phase_done
    tick(3'd1, 1'b1);
    tick(3'd4, 1'b1);
    repeat (PH - 1) tick(3'd0, 1'b0);
    chk("runc_busy_last", bus.busy, 1'b1);
    chk("runc_pd_early", bus.phase_done, 1'b0);
    tick(3'd0, 1'b0);
    chk("runc_busy_end", bus.busy, 1'b0);
    chk("runc_pd_end", bus.phase_done, 1'b1);
    tick(3'd0, 1'b0);
    chk("runc_pd_once", bus.phase_done, 1'b0);

    // B, P: RUN_P then FINISH, two pulses
    pd0 = pd_cnt;
    tick(3'd2, 1'b1);
    tick(3'd3, 1'b1);
    repeat (2 * PH + 6) tick(3'd0, 1'b0);
    chk("bp_pd_pulses", pd_cnt - pd0, 2);
    chk("bp_busy_end", bus.busy, 1'b0);

    // RUN_E ignores A; CANCEL on the expiry edge wins with no pulse
    pd0 = pd_cnt;
    tick(3'd1, 1'b1);
    tick(3'd5, 1'b1);
    repeat (4) tick(3'd0, 1'b0);
    tick(3'd1, 1'b1);
    chk("rune_ignore_a", bus.busy, 1'b1);
    repeat (PH - 6) tick(3'd0, 1'b0);
    tick(3'd7, 1'b1);
    chk("cancel_busy", bus.busy, 1'b0);
    chk("cancel_pd", bus.phase_done, 1'b0);
    repeat (9) tick(3'd0, 1'b0);
    chk("cancel_no_pd", pd_cnt - pd0, 0);
    chk("cancel_letter", last_seg[0], lseg("H"));
    chk("cancel_grp", last_seg[DIGITS-1], 8'h00);

    // async reset in the middle of RUN_P, then a clean restart
    tick(3'd1, 1'b1);
    tick(3'd3, 1'b1);
    repeat (5) tick(3'd0, 1'b0);
    chk("pre_rst_busy", bus.busy, 1'b1);
    do_reset("midrst");
    repeat (9) tick(3'd0, 1'b0);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_letter", last_seg[0], lseg("H"));
    chk("post_rst_d1", last_seg[1], 8'h00);
    tick(3'd2, 1'b1);
    repeat (9) tick(3'd0, 1'b0);
    chk("post_rst_selb", last_seg[0], lseg("B"));
    chk("post_rst_grp", last_seg[DIGITS-1], lseg("B"));

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_menu_ctrl.md
# seg_menu_ctrl

Parametrised menu/sequence controller for the 7-segment user interface. It accepts 3-bit operator commands, walks a two-level selection FSM with timed run and finish phases, and owns its own tick prescaler and phase countdown, so no external timer handshake is needed. It drives a time-multiplexed DIGITS-wide display showing the current state letter, the remaining phase ticks and the selected group.

## Interface
- DIGITS, 4: number of display digits; legal range 3..8.
- SCAN_DIV, 1000: clk cycles per digit slot; must be ≥1.
- TICK_DIV, 50_000_000: clk cycles per phase tick; must be ≥1.
- PHASE_TICKS, 3: ticks per timed phase; legal range 1..9.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cmd  in  3  command code: A=1, B=2, P=3, C=4, E=5, CANCEL=7; 0 and 6 are ignored.
- cmd_valid  in  1  qualifies cmd for one cycle.
- seg  out  8  segment bits {a,b,c,d,e,f,g,dp}, active-high; registered.
- an  out  DIGITS  one-hot digit enable, active-high; registered.
- busy  out  1  high in RUN_P, RUN_C, RUN_E and FINISH; registered.
- phase_done  out  1  one-cycle pulse on natural expiry of a timed phase; registered.

## Operation
- States, transitions taken only when cmd_valid=1:
  - IDLE: A→SEL_A; B→SEL_B.
  - SEL_A / SEL_B: P→RUN_P; C→RUN_C; E→RUN_E.
  - Any other cmd holds state. There is no unspecified hold path.
- CANCEL from any non-IDLE state goes to IDLE. It has priority over expiry in the same cycle and produces no phase_done.
- Timed states:
  - RUN_P→FINISH on expiry.
  - RUN_C→IDLE, RUN_E→IDLE and FINISH→IDLE on expiry.
  - Commands other than CANCEL are ignored.
- Group register:
  - Set to A or B on entry to SEL_A or SEL_B.
  - Cleared on entry to IDLE.
- Digit contents:
  - Digit 0 shows the state letter: IDLE H, SEL_A A, SEL_B B, RUN_P P, RUN_C C, RUN_E E, FINISH G.
  - Digit 1 shows the remaining ticks in decimal in timed states; blank otherwise.
  - Digit DIGITS-1 shows the group letter, or blank.
  - All other digits are blank.
- Segment codes:
  - Letters: H 01101110, A 11101110, B 11111110, P 11001110, C 10011100, E 10011110, G 10111110, blank 00000000.
  - Digits 0–9: 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100000, 11111110, 11110110.

## Timing
- Reset values: state IDLE, group cleared, seg=0, an=0, busy=0, phase_done=0, all counters 0.
- cmd is sampled at a posedge with cmd_valid=1. The new state is visible in busy and seg/an data from the next cycle.
- Timed-state entry:
  - Prescaler is cleared.
  - remaining is loaded with PHASE_TICKS.
- Tick counting:
  - The prescaler counts 0..TICK_DIV-1.
  - At wrap, remaining decrements.
  - At wrap with remaining=1, the state expires.
  - Each timed state therefore lasts exactly PHASE_TICKS×TICK_DIV cycles.
- phase_done is high in the first cycle of the successor state. RUN_P→FINISH→IDLE yields two pulses.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1.
  - At wrap, the digit index advances and wraps DIGITS-1→0.
  - seg and an are registered together, so they are always coherent.
  - The first posedge after reset release drives an=digit 0.
- A state change mid-scan updates the content of the current slot one cycle later. The scan position is unaffected.
- Asynchronous rst mid-phase aborts immediately to the reset values.

## Configuration
- SEG_ACTIVE_LOW_EN defined: seg and an are inverted at the output registers for common-anode boards. The reset value is then seg=8'hFF and an all-ones.
- SEG_ACTIVE_LOW_EN undefined: outputs are active-high as specified above.

## Structure
- Package seg_menu_pkg holds:
  - the state enum;
  - the command code constants;
  - the letter and digit segment constants, including blank;
  - a function mapping 0–9 to a segment code.
- Sub-module seg_scan (parameters DIGITS, SCAN_DIV) holds the scan counter and digit index.
  - It takes the packed per-digit codes.
  - It outputs registered seg/an and applies the SEG_ACTIVE_LOW_EN inversion.
- seg_menu_ctrl holds the FSM, prescaler, countdown and group register.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=2, TICK_DIV=4, PHASE_TICKS=3.
- Reset release with no cmd → state IDLE and busy=0.
  - seg=01101110 whenever an=0001.
  - Digits 1–3 blank.
  - an cycles 0001→0010→0100→1000 every 2 cycles.
- Sequence cmd A then cmd C, each valid for 1 cycle → digit 3 shows A.
  - RUN_C is entered and busy=1.
  - Digit 1 shows 3, then 2, then 1.
  - After 12 cycles: IDLE, phase_done high for 1 cycle, busy=0.
- Sequence cmd B then cmd P → RUN_P for 12 cycles, then FINISH showing G for 12 cycles, then IDLE.
  - Exactly two phase_done pulses.
- In RUN_E, cmd A is ignored; CANCEL presented at the expiry cycle → IDLE with no phase_done.
- cmd 0, cmd 6, and cmd with cmd_valid=0 in IDLE and SEL_B → no state change.
- rst asserted mid RUN_P → immediate seg=0, an=0, busy=0; the FSM restarts in IDLE.
  - Rerun the same checks with SEG_ACTIVE_LOW_EN defined: seg=FF and an=1111 during reset.
